// File: rtl/dram_burst_writer.sv
// Packs 32-bit producer words into 8-word DRAM write bursts: two 128-bit wdf beats, then one af write command.
// Latency: beat 0 two cycles after the 8th word, beat 1 one cycle later, command one cycle after that.
// Backpressure: in_ready drops while the fill block is still pending/draining; wdf_full/af_full stall the drain FSM.
module dram_burst_writer #(
    parameter int ADDR_STEP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [30:0]  start_addr,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    input  logic         flush,
    output logic         busy,
    output logic         af_wr_en,
    output logic [2:0]   af_cmd_din,
    output logic [30:0]  af_addr_din,
    input  logic         af_full,
    output logic         wdf_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    input  logic         wdf_full
);

    typedef enum logic [1:0] {IDLE, WDF1, WDF2, CMD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [16];
    logic          fill_blk, drain_blk;
    logic [2:0]    ptr;
    logic [1:0]    blk_full;
    logic [3:0]    blk_cnt [2];
    logic [30:0]   addr;

    logic          accept, close_blk, af_push;
    logic [3:0]    close_cnt;
    logic          beat_sel;
    logic [127:0]  beat_dat;
    logic [15:0]   beat_msk;

    assign in_ready    = !blk_full[fill_blk];
    assign busy        = (state != IDLE) || (|blk_full) || (ptr != 3'd0);
    assign af_cmd_din  = 3'b000;
    assign af_addr_din = addr;
    assign af_push     = af_wr_en;

    // A flush arriving with an accepted word closes the block after that word is stored.
    assign accept    = in_valid && in_ready;
    assign close_blk = (accept && ptr == 3'd7) || (flush && (accept || ptr != 3'd0));
    assign close_cnt = accept ? {1'b0, ptr} + 4'd1 : {1'b0, ptr};

    always_ff @(posedge clk) begin
        if (accept)
            mem[{fill_blk, ptr}] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fill_blk   <= 1'b0;
            drain_blk  <= 1'b0;
            ptr        <= 3'd0;
            blk_full   <= 2'b00;
            blk_cnt[0] <= 4'd0;
            blk_cnt[1] <= 4'd0;
            addr       <= 31'd0;
        end else begin
            state <= state_nxt;
            if (close_blk) begin
                blk_full[fill_blk] <= 1'b1;
                blk_cnt[fill_blk]  <= close_cnt;
                ptr                <= 3'd0;
                fill_blk           <= ~fill_blk;
            end else if (accept) begin
                ptr <= ptr + 3'd1;
            end
            // The draining block is always full, so it never collides with the fill block set above.
            if (af_push) begin
                blk_full[drain_blk] <= 1'b0;
                drain_blk           <= ~drain_blk;
                addr                <= addr + 31'(ADDR_STEP);
            end else if (start && !busy) begin
                addr <= start_addr;
            end
        end
    end

    always_comb begin
        beat_sel = (state == WDF2);
        beat_dat = '0;
        beat_msk = '0;
        for (int j = 0; j < 4; j++) begin
            beat_dat[32*j +: 32] = mem[{drain_blk, beat_sel, 2'(j)}];
            beat_msk[4*j +: 4]   = ({1'b0, beat_sel, 2'(j)} >= blk_cnt[drain_blk]) ? 4'hF : 4'h0;
        end
    end

    always_comb begin
        state_nxt    = state;
        wdf_wr_en    = 1'b0;
        af_wr_en     = 1'b0;
        wdf_din      = '0;
        wdf_mask_din = '0;
        case (state)
            IDLE: begin
                if (blk_full[drain_blk])
                    state_nxt = WDF1;
            end
            WDF1, WDF2: begin
                wdf_wr_en    = !wdf_full;
                wdf_din      = beat_dat;
                wdf_mask_din = beat_msk;
                if (!wdf_full)
                    state_nxt = (state == WDF1) ? WDF2 : CMD;
            end
            CMD: begin
                af_wr_en = !af_full;
                if (!af_full)
                    state_nxt = blk_full[~drain_blk] ? WDF1 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dram_burst_writer.sv
// Bench for dram_burst_writer: random words against a queue-based burst model plus targeted timing/backpressure scenarios.
module tb_dram_burst_writer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [30:0]  start_addr = '0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic         busy;
    logic         af_wr_en;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         af_full = 1'b0;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_full = 1'b0;

    dram_burst_writer #(.ADDR_STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .flush(flush),
        .busy(busy), .af_wr_en(af_wr_en), .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din),
        .af_full(af_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din),
        .wdf_mask_din(wdf_mask_din), .wdf_full(wdf_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed pushes, recorded mid-cycle when inputs and state are both settled.
    logic [127:0] h_dat[$];
    logic [15:0]  h_msk[$];
    int           h_cyc[$];
    logic [30:0]  h_addr[$];
    logic [2:0]   h_cmd[$];
    int           h_acyc[$];
    int           h_nb[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (wdf_wr_en) begin
                if (wdf_full) viol++;
                h_dat.push_back(wdf_din);
                h_msk.push_back(wdf_mask_din);
                h_cyc.push_back(cyc);
            end
            if (af_wr_en) begin
                if (af_full) viol++;
                h_addr.push_back(af_addr_din);
                h_cmd.push_back(af_cmd_din);
                h_acyc.push_back(cyc);
                h_nb.push_back(h_dat.size());
            end
        end
    end

    // Reference model: a burst is whatever words were collected when 8 arrive or a flush closes them.
    typedef struct packed {
        logic [30:0]  addr;
        logic [255:0] words;
        logic [3:0]   n;
    } burst_t;

    burst_t      exp_q[$];
    logic [31:0] cur[$];
    logic [30:0] m_addr = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_close();
        burst_t b;
        if (cur.size() > 0) begin
            b.addr  = m_addr;
            b.words = '0;
            b.n     = 4'(cur.size());
            for (int k = 0; k < cur.size(); k++) b.words[32*k +: 32] = cur[k];
            exp_q.push_back(b);
            m_addr = m_addr + 31'd4;
            cur.delete();
        end
    endtask

    task automatic do_start(input logic [30:0] a);
        start = 1'b1;
        start_addr = a;
        m_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_close();
    endtask

    task automatic send_word(input logic [31:0] d, input logic fl, output bit ok,
                             output int waited, output int acc);
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        ok  = in_ready;
        acc = cyc;
        if (ok) flush = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        if (ok) begin
            cur.push_back(d);
            if (cur.size() == 8) model_close();
            if (fl) model_close();
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (af_wr_en !== 1'b0) begin bad++; $display("FAIL reset_af_wr_en got=%b want=0", af_wr_en); end
        total++; if (wdf_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wdf_wr_en got=%b want=0", wdf_wr_en); end
        total++; if (af_addr_din !== 31'd0) begin bad++; $display("FAIL reset_af_addr got=%h want=0", af_addr_din); end
        total++; if (wdf_din !== 128'd0) begin bad++; $display("FAIL reset_wdf_din got=%h want=0", wdf_din); end
        total++; if (wdf_mask_din !== 16'd0) begin bad++; $display("FAIL reset_mask got=%h want=0", wdf_mask_din); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int w, acc, t, nb0, nc0, g;
        logic [127:0] e0, e1;
        e0 = {32'd3, 32'd2, 32'd1, 32'd0};
        e1 = {32'd7, 32'd6, 32'd5, 32'd4};
        do_start(31'h100);
        nb0 = h_dat.size();
        nc0 = h_addr.size();
        for (int k = 0; k < 8; k++) send_word(32'(k), 1'b0, ok, w, acc);
        t = acc;
        g = 0;
        while (cyc < t + 4 && g < 20) begin tick(); g++; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_t4 got=%b want=1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_t5 got=%b want=0", busy); end
        total++;
        if (h_dat.size() != nb0 + 2 || h_addr.size() != nc0 + 1) begin
            bad++;
            $display("FAIL single_counts beats=%0d cmds=%0d want=2,1", h_dat.size() - nb0, h_addr.size() - nc0);
        end else begin
            total++; if (h_dat[nb0] !== e0) begin bad++; $display("FAIL single_beat0 got=%h want=%h", h_dat[nb0], e0); end
            total++; if (h_dat[nb0+1] !== e1) begin bad++; $display("FAIL single_beat1 got=%h want=%h", h_dat[nb0+1], e1); end
            total++; if (h_msk[nb0] !== 16'h0 || h_msk[nb0+1] !== 16'h0) begin bad++; $display("FAIL single_mask got=%h,%h want=0,0", h_msk[nb0], h_msk[nb0+1]); end
            total++; if (h_addr[nc0] !== 31'h100) begin bad++; $display("FAIL single_addr got=%h want=100", h_addr[nc0]); end
            total++; if (h_cyc[nb0] != t + 2) begin bad++; $display("FAIL single_beat0_cycle got=%0d want=%0d", h_cyc[nb0], t + 2); end
            total++; if (h_cyc[nb0+1] != t + 3) begin bad++; $display("FAIL single_beat1_cycle got=%0d want=%0d", h_cyc[nb0+1], t + 3); end
            total++; if (h_acyc[nc0] != t + 4) begin bad++; $display("FAIL single_cmd_cycle got=%0d want=%0d", h_acyc[nc0], t + 4); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int w, acc, maxw, nc0;
        maxw = 0;
        do_start(31'h100);
        nc0 = h_addr.size();
        for (int k = 0; k < 24; k++) begin
            send_word($urandom, 1'b0, ok, w, acc);
            if (w > maxw) maxw = w;
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_idle busy=%b want=0", busy); end
        total++; if (maxw > 1) begin bad++; $display("FAIL b2b_stall got=%0d want<=1", maxw); end
        total++;
        if (h_addr.size() != nc0 + 3) begin
            bad++; $display("FAIL b2b_cmds got=%0d want=3", h_addr.size() - nc0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (h_addr[nc0+i] !== 31'h100 + 31'(4 * i)) begin
                    bad++; $display("FAIL b2b_addr%0d got=%h want=%h", i, h_addr[nc0+i], 31'h100 + 31'(4 * i));
                end
            end
        end
    endtask

    task automatic test_flush();
        bit ok;
        int w, acc, nb0, nc0;
        nb0 = h_dat.size();
        for (int k = 0; k < 3; k++) send_word($urandom, 1'b0, ok, w, acc);
        pulse_flush();
        wait_idle(ok);
        total++;
        if (h_dat.size() != nb0 + 2) begin
            bad++; $display("FAIL flush3_beats got=%0d want=2", h_dat.size() - nb0);
        end else begin
            total++; if (h_msk[nb0] !== 16'hF000) begin bad++; $display("FAIL flush3_mask0 got=%h want=f000", h_msk[nb0]); end
            total++; if (h_msk[nb0+1] !== 16'hFFFF) begin bad++; $display("FAIL flush3_mask1 got=%h want=ffff", h_msk[nb0+1]); end
        end
        nb0 = h_dat.size();
        nc0 = h_addr.size();
        pulse_flush();
        repeat (10) tick();
        total++; if (h_dat.size() != nb0 || h_addr.size() != nc0 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_empty beats=%0d cmds=%0d busy=%b want=0,0,0", h_dat.size() - nb0, h_addr.size() - nc0, busy);
        end
        nb0 = h_dat.size();
        send_word($urandom, 1'b0, ok, w, acc);
        send_word($urandom, 1'b1, ok, w, acc);
        wait_idle(ok);
        total++;
        if (h_dat.size() != nb0 + 2) begin
            bad++; $display("FAIL flush_with_word_beats got=%0d want=2", h_dat.size() - nb0);
        end else if (h_msk[nb0] !== 16'hFF00) begin
            bad++; $display("FAIL flush_with_word_mask got=%h want=ff00", h_msk[nb0]);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int w, acc, nb0, nc0, g;
        nb0 = h_dat.size();
        nc0 = h_addr.size();
        for (int k = 0; k < 8; k++) send_word($urandom, 1'b0, ok, w, acc);
        g = 0;
        while (!wdf_wr_en && g < 50) begin tick(); g++; end
        tick();
        wdf_full = 1'b1;
        repeat (10) tick();
        wdf_full = 1'b0;
        tick();
        af_full = 1'b1;
        repeat (5) tick();
        af_full = 1'b0;
        wait_idle(ok);
        total++; if (viol != 0) begin bad++; $display("FAIL bp_enable_while_full got=%0d want=0", viol); end
        total++; if (h_dat.size() != nb0 + 2) begin bad++; $display("FAIL bp_beats got=%0d want=2", h_dat.size() - nb0); end
        total++; if (h_addr.size() != nc0 + 1) begin bad++; $display("FAIL bp_cmds got=%0d want=1", h_addr.size() - nc0); end
        total++;
        if (h_dat.size() == nb0 + 2 && h_addr.size() == nc0 + 1) begin
            if (h_cyc[nb0+1] - h_cyc[nb0] < 11 || h_acyc[nc0] - h_cyc[nb0+1] < 6) begin
                bad++; $display("FAIL bp_spacing got=%0d,%0d want>=11,>=6", h_cyc[nb0+1] - h_cyc[nb0], h_acyc[nc0] - h_cyc[nb0+1]);
            end
        end else begin
            bad++; $display("FAIL bp_spacing got=missing want=present");
        end
    endtask

    task automatic test_fill_both();
        bit ok;
        int w, acc, nacc, nc0, g;
        logic [31:0] d17;
        nacc = 0;
        wdf_full = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send_word($urandom, 1'b0, ok, w, acc);
            if (ok && w == 0) nacc++;
        end
        total++; if (nacc != 16) begin bad++; $display("FAIL fill16_accepted got=%0d want=16", nacc); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill16_in_ready got=%b want=0", in_ready); end
        d17 = $urandom;
        in_valid = 1'b1;
        in_data  = d17;
        repeat (5) tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL word17_held got=%b want=0", in_ready); end
        nc0 = h_addr.size();
        wdf_full = 1'b0;
        g = 0;
        while (!in_ready && g < 50) begin tick(); g++; end
        total++; if (h_addr.size() != nc0 + 1) begin bad++; $display("FAIL word17_release cmds=%0d want=1", h_addr.size() - nc0); end
        tick();
        in_valid = 1'b0;
        if (g < 50) cur.push_back(d17);
        pulse_flush();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL fill_both_idle busy=%b want=0", busy); end
    endtask

    task automatic test_scoreboard();
        burst_t b;
        logic [15:0] em;
        total++;
        if (h_addr.size() != exp_q.size() || h_dat.size() != 2 * exp_q.size()) begin
            bad++; $display("FAIL sb_counts cmds=%0d beats=%0d want=%0d,%0d", h_addr.size(), h_dat.size(), exp_q.size(), 2 * exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                b = exp_q[i];
                total++; if (h_addr[i] !== b.addr) begin bad++; $display("FAIL sb_addr%0d got=%h want=%h", i, h_addr[i], b.addr); end
                total++; if (h_cmd[i] !== 3'b000) begin bad++; $display("FAIL sb_cmd%0d got=%b want=000", i, h_cmd[i]); end
                total++; if (h_nb[i] != 2 * (i + 1)) begin bad++; $display("FAIL sb_order%0d beats_before_cmd=%0d want=%0d", i, h_nb[i], 2 * (i + 1)); end
                for (int bt = 0; bt < 2; bt++) begin
                    for (int j = 0; j < 4; j++) em[4*j +: 4] = (4 * bt + j >= int'(b.n)) ? 4'hF : 4'h0;
                    total++; if (h_msk[2*i+bt] !== em) begin bad++; $display("FAIL sb_mask%0d_%0d got=%h want=%h", i, bt, h_msk[2*i+bt], em); end
                end
                for (int k = 0; k < int'(b.n); k++) begin
                    total++;
                    if (h_dat[2*i + k/4][32*(k%4) +: 32] !== b.words[32*k +: 32]) begin
                        bad++; $display("FAIL sb_word%0d_%0d got=%h want=%h", i, k, h_dat[2*i + k/4][32*(k%4) +: 32], b.words[32*k +: 32]);
                    end
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int w, acc, g, nb0, nc0;
        do_start(31'h200);
        for (int k = 0; k < 8; k++) send_word($urandom, 1'b0, ok, w, acc);
        g = 0;
        while (!wdf_wr_en && g < 50) begin tick(); g++; end
        tick();
        rst = 1'b1;
        tick();
        total++; if (af_wr_en !== 1'b0 || wdf_wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_enables got=%b%b want=00", af_wr_en, wdf_wr_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        cur.delete();
        nb0 = h_dat.size();
        nc0 = h_addr.size();
        repeat (10) tick();
        total++; if (h_dat.size() != nb0 || h_addr.size() != nc0) begin bad++; $display("FAIL rst_mid_quiet beats=%0d cmds=%0d want=0,0", h_dat.size() - nb0, h_addr.size() - nc0); end
        do_start(31'h300);
        for (int k = 0; k < 3; k++) send_word($urandom, 1'b0, ok, w, acc);
        start = 1'b1;
        start_addr = 31'h500;
        tick();
        start = 1'b0;
        pulse_flush();
        wait_idle(ok);
        total++;
        if (h_addr.size() != nc0 + 1) begin
            bad++; $display("FAIL start_busy_cmds got=%0d want=1", h_addr.size() - nc0);
        end else if (h_addr[nc0] !== 31'h300) begin
            bad++; $display("FAIL start_busy_addr got=%h want=300", h_addr[nc0]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_backpressure();
        test_fill_both();
        test_scoreboard();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
